ahb_lite_arbiter: RTL and testbench

Two-master AHB-lite arbiter and bus multiplexer placed in front of the single AHB-lite memory slave. Two requesters share the memory through it. It grants the address phase round-robin and never breaks a fixed-length burst. It steers address/control from the address-phase owner and HWDATA from the data-phase owner, and broadcasts HREADY/HRESP/HRDATA back to both masters.

---
 rtl/ahb_lite_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_ahb_lite_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_arbiter.sv
// Two-master AHB-lite arbiter and bus mux in front of a single slave.
// Round-robin address-phase grant that never splits a fixed-length burst.
module ahb_lite_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,

  input  logic              HBUSREQ_0,
  input  logic              HBUSREQ_1,
  output logic              HGRANT_0,
  output logic              HGRANT_1,

  input  logic [ADDR_W-1:0] HADDR_0,
  input  logic [1:0]        HTRANS_0,
  input  logic              HWRITE_0,
  input  logic [2:0]        HSIZE_0,
  input  logic [2:0]        HBURST_0,
  input  logic [3:0]        HPROT_0,
  input  logic [DATA_W-1:0] HWDATA_0,

  input  logic [ADDR_W-1:0] HADDR_1,
  input  logic [1:0]        HTRANS_1,
  input  logic              HWRITE_1,
  input  logic [2:0]        HSIZE_1,
  input  logic [2:0]        HBURST_1,
  input  logic [3:0]        HPROT_1,
  input  logic [DATA_W-1:0] HWDATA_1,

  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  output logic              HSEL,

  input  logic              HREADYOUT,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic              HMASTER,

  output logic              HRESP_0,
  output logic              HRESP_1,
  output logic [DATA_W-1:0] HRDATA_0,
  output logic [DATA_W-1:0] HRDATA_1
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;
  localparam logic [2:0] BURST_INCR16 = 3'b111;

  logic       grant_q, grant_d;
  logic       addr_owner_q, addr_owner_d;
  logic       data_owner_q, data_owner_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic       last_won_q, last_won_d;

  logic       hready;
  logic [1:0] htrans_g;
  logic [2:0] hburst_g;
  logic       hbusreq_g;
  logic       locked;
  logic       holding;
  logic       arb_ok;

  // Slave-side mux: address/control from the address-phase owner,
  // write data from the data-phase owner.
  always_comb begin
    hready  = HREADYOUT;
    HREADY  = hready;
    HMASTER = addr_owner_q;
    HGRANT_0 = ~grant_q;
    HGRANT_1 = grant_q;

    HADDR  = addr_owner_q ? HADDR_1  : HADDR_0;
    HTRANS = addr_owner_q ? HTRANS_1 : HTRANS_0;
    HWRITE = addr_owner_q ? HWRITE_1 : HWRITE_0;
    HSIZE  = addr_owner_q ? HSIZE_1  : HSIZE_0;
    HBURST = addr_owner_q ? HBURST_1 : HBURST_0;
    HPROT  = addr_owner_q ? HPROT_1  : HPROT_0;
    HWDATA = data_owner_q ? HWDATA_1 : HWDATA_0;
    HSEL   = HTRANS[1];

    HRESP_0  = HRESP;
    HRESP_1  = HRESP;
    HRDATA_0 = HRDATA;
    HRDATA_1 = HRDATA;
  end

  // Arbitration looks at the granted master, which during a handover is not
  // yet the address-phase owner.
  always_comb begin
    htrans_g  = grant_q ? HTRANS_1  : HTRANS_0;
    hburst_g  = grant_q ? HBURST_1  : HBURST_0;
    hbusreq_g = grant_q ? HBUSREQ_1 : HBUSREQ_0;

    locked  = (beat_cnt_q != 4'd0);
    holding = 1'b1;
    if (htrans_g == TRANS_IDLE) begin
      holding = 1'b0;
    end else if ((htrans_g == TRANS_NONSEQ) && !hbusreq_g &&
                 ((hburst_g == BURST_SINGLE) || (hburst_g == BURST_INCR))) begin
      holding = 1'b0;
    end
    arb_ok = hready && !locked && !holding;
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (!hready && HRESP) begin
      beat_cnt_d = '0;
    end else if (hready) begin
      if (HTRANS == TRANS_NONSEQ) begin
        case (HBURST)
          BURST_INCR4,  BURST_WRAP4:  beat_cnt_d = 4'd3;
          BURST_INCR8,  BURST_WRAP8:  beat_cnt_d = 4'd7;
          BURST_INCR16, BURST_WRAP16: beat_cnt_d = 4'd15;
          default:                    beat_cnt_d = '0;
        endcase
      end else if ((HTRANS == TRANS_SEQ) && (beat_cnt_q != 4'd0)) begin
        beat_cnt_d = beat_cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    grant_d    = grant_q;
    last_won_d = last_won_q;
    if (arb_ok) begin
      if (HBUSREQ_0 && HBUSREQ_1) begin
        grant_d = ~last_won_q;
      end else if (HBUSREQ_1) begin
        grant_d = 1'b1;
      end else begin
        grant_d = 1'b0;
      end
      if (HBUSREQ_0 || HBUSREQ_1) begin
        last_won_d = grant_d;
      end
    end
  end

  always_comb begin
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    if (hready) begin
      data_owner_d = addr_owner_q;
      addr_owner_d = grant_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      grant_q      <= 1'b0;
      addr_owner_q <= 1'b0;
      data_owner_q <= 1'b0;
      beat_cnt_q   <= '0;
      last_won_q   <= 1'b1;
    end else begin
      grant_q      <= grant_d;
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      last_won_q   <= last_won_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Directed bench for ahb_lite_arbiter: handover, burst lock, round-robin,
// wait states, ERROR abort and mid-burst reset.
module tb_ahb_lite_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR4 = 3'b011, B_WRAP8 = 3'b100;
  localparam logic [2:0] B_INCR8 = 3'b101, B_INCR16 = 3'b111;

  logic        HCLK, HRESET;
  logic        HBUSREQ_0, HBUSREQ_1, HGRANT_0, HGRANT_1;
  logic [31:0] HADDR_0, HADDR_1, HWDATA_0, HWDATA_1;
  logic [1:0]  HTRANS_0, HTRANS_1;
  logic        HWRITE_0, HWRITE_1;
  logic [2:0]  HSIZE_0, HSIZE_1, HBURST_0, HBURST_1;
  logic [3:0]  HPROT_0, HPROT_1;
  logic [31:0] HADDR, HWDATA, HRDATA, HRDATA_0, HRDATA_1;
  logic [1:0]  HTRANS;
  logic        HWRITE, HSEL, HREADYOUT, HRESP, HREADY, HMASTER, HRESP_0, HRESP_1;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int checks = 0;
  int failures = 0;

  ahb_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HBUSREQ_0(HBUSREQ_0), .HBUSREQ_1(HBUSREQ_1),
    .HGRANT_0(HGRANT_0), .HGRANT_1(HGRANT_1),
    .HADDR_0(HADDR_0), .HTRANS_0(HTRANS_0), .HWRITE_0(HWRITE_0), .HSIZE_0(HSIZE_0),
    .HBURST_0(HBURST_0), .HPROT_0(HPROT_0), .HWDATA_0(HWDATA_0),
    .HADDR_1(HADDR_1), .HTRANS_1(HTRANS_1), .HWRITE_1(HWRITE_1), .HSIZE_1(HSIZE_1),
    .HBURST_1(HBURST_1), .HPROT_1(HPROT_1), .HWDATA_1(HWDATA_1),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HSEL(HSEL),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .HREADY(HREADY), .HMASTER(HMASTER),
    .HRESP_0(HRESP_0), .HRESP_1(HRESP_1), .HRDATA_0(HRDATA_0), .HRDATA_1(HRDATA_1)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input bit m, input logic [1:0] tr, input logic [2:0] bu,
                       input logic [31:0] ad, input bit wr);
    if (m) begin
      HTRANS_1 = tr; HBURST_1 = bu; HADDR_1 = ad; HWRITE_1 = wr;
    end else begin
      HTRANS_0 = tr; HBURST_0 = bu; HADDR_0 = ad; HWRITE_0 = wr;
    end
  endtask

  task automatic wd(input bit m, input logic [31:0] d);
    if (m) HWDATA_1 = d; else HWDATA_0 = d;
  endtask

  task automatic do_reset;
    HRESET = 1'b0;
    #1;
    chk("rst_grant0", HGRANT_0, 1);
    chk("rst_grant1", HGRANT_1, 0);
    chk("rst_hmaster", HMASTER, 0);
    chk("rst_beat", dut.beat_cnt_q, 0);
    drive(0, T_IDLE, B_SINGLE, 0, 0);
    drive(1, T_IDLE, B_SINGLE, 0, 0);
    HREADYOUT = 1'b1; HRESP = 1'b0;
    #1;
    HRESET = 1'b1;
  endtask

  initial begin
    bit ge, ao;
    HRESET = 1'b1; HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_BEEF;
    HBUSREQ_0 = 1'b1; HBUSREQ_1 = 1'b1;
    HSIZE_0 = 3'd2; HSIZE_1 = 3'd2; HPROT_0 = 4'h3; HPROT_1 = 4'hB;
    drive(0, T_IDLE, B_SINGLE, 0, 0); drive(1, T_IDLE, B_SINGLE, 0, 0);
    wd(0, 0); wd(1, 32'h1111_1111);
    #1 HRESET = 1'b0;
    tick; tick;
    chk("reset_grant0", HGRANT_0, 1);
    chk("reset_grant1", HGRANT_1, 0);
    chk("reset_hmaster", HMASTER, 0);
    chk("reset_hwdata", HWDATA, 0);
    chk("hrdata_bcast", HRDATA_1, 32'hDEAD_BEEF);
    HRESET = 1'b1;

    // SINGLE from master 0 then handover to master 1
    drive(0, T_NONSEQ, B_SINGLE, 32'h10, 1);
    HBUSREQ_0 = 1'b0; HBUSREQ_1 = 1'b1;
    #1;
    chk("t1_hsel", HSEL, 1);
    chk("t1_haddr", HADDR, 32'h10);
    chk("t1_hprot", HPROT, 4'h3);
    tick;
    chk("t1_grant1", HGRANT_1, 1);
    chk("t1_grant0", HGRANT_0, 0);
    chk("t1_hmaster_e1", HMASTER, 0);
    drive(0, T_IDLE, B_SINGLE, 0, 0); wd(0, 32'hA0A0_0010);
    #1;
    chk("t1_hwdata", HWDATA, 32'hA0A0_0010);
    tick;
    chk("t1_hmaster_e2", HMASTER, 1);
    chk("t1_hprot_m1", HPROT, 4'hB);

    // INCR4 from master 0; master 1 requests throughout
    HBUSREQ_1 = 1'b0; HBUSREQ_0 = 1'b1;
    tick;
    chk("t2_grant0", HGRANT_0, 1);
    tick;
    chk("t2_hmaster0", HMASTER, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 0) ? T_NONSEQ : T_SEQ, B_INCR4, 32'h100 + 32'(4 * i), 1);
      if (i > 0) wd(0, 32'hB000_0000 + 32'(i - 1));
      HBUSREQ_1 = 1'b1;
      tick;
      chk("t2_burst_grant0", HGRANT_0, 1);
      chk("t2_burst_beat", dut.beat_cnt_q, 64'(3 - i));
    end
    drive(0, T_IDLE, B_SINGLE, 0, 0); wd(0, 32'hB000_0003);
    HBUSREQ_0 = 1'b0;
    #1;
    chk("t2_beat4_data", HWDATA, 32'hB000_0003);
    tick;
    chk("t2_grant1", HGRANT_1, 1);
    chk("t2_hmaster_hold", HMASTER, 0);
    drive(1, T_NONSEQ, B_SINGLE, 32'h800, 0);
    tick;
    chk("t2_hmaster1", HMASTER, 1);
    chk("t2_haddr_m1", HADDR, 32'h800);
    chk("t2_hwdata_m0", HWDATA, 32'hB000_0003);

    // Round-robin with both requests held
    do_reset();
    HBUSREQ_0 = 1'b1; HBUSREQ_1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      ge = (k % 2 == 0);
      ao = (k >= 2) && (k % 2 == 1);
      chk("t3_grant1", HGRANT_1, 64'(ge));
      chk("t3_hmaster", HMASTER, 64'(ao));
      drive(0, T_IDLE, B_SINGLE, 0, 0);
      drive(1, T_IDLE, B_SINGLE, 0, 0);
      if (ao != ge) begin
        drive(ao, T_NONSEQ, B_SINGLE, 32'h200 + 32'(4 * k), 0);
        #1;
        chk("t3_haddr", HADDR, 32'h200 + 64'(4 * k));
        chk("t3_hsel", HSEL, 1);
      end
    end

    // WRAP8 with three wait states mid-burst
    do_reset();
    HBUSREQ_0 = 1'b1; HBUSREQ_1 = 1'b0;
    tick;
    chk("t4_grant0", HGRANT_0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, (i == 0) ? T_NONSEQ : T_SEQ, B_WRAP8, 32'h300 + 32'(4 * i), 0);
      if (i == 2) HBUSREQ_1 = 1'b1;
      if (i == 3) begin
        HREADYOUT = 1'b0;
        #1;
        chk("t4_hready_low", HREADY, 0);
        for (int s = 0; s < 3; s++) begin
          tick;
          chk("t4_stall_grant", HGRANT_0, 1);
          chk("t4_stall_hmaster", HMASTER, 0);
          chk("t4_stall_beat", dut.beat_cnt_q, 5);
        end
        HREADYOUT = 1'b1;
      end
      tick;
      chk("t4_beat", dut.beat_cnt_q, 64'(7 - i));
      chk("t4_burst_grant0", HGRANT_0, 1);
    end
    drive(0, T_IDLE, B_SINGLE, 0, 0);
    HBUSREQ_0 = 1'b0;
    tick;
    chk("t4_grant1", HGRANT_1, 1);

    // ERROR on beat 2 of INCR16 from master 1, master 0 requesting
    tick;
    chk("t5_hmaster1", HMASTER, 1);
    drive(1, T_NONSEQ, B_INCR16, 32'h400, 1);
    HBUSREQ_0 = 1'b1;
    tick;
    chk("t5_beat15", dut.beat_cnt_q, 15);
    drive(1, T_SEQ, B_INCR16, 32'h404, 1);
    tick;
    chk("t5_beat14", dut.beat_cnt_q, 14);
    drive(1, T_SEQ, B_INCR16, 32'h408, 1);
    HREADYOUT = 1'b0; HRESP = 1'b1;
    #1;
    chk("t5_hresp_bcast", HRESP_0, 1);
    tick;
    chk("t5_err_beat", dut.beat_cnt_q, 0);
    chk("t5_err_grant1", HGRANT_1, 1);
    chk("t5_err_hmaster", HMASTER, 1);
    HREADYOUT = 1'b1;
    drive(1, T_IDLE, B_SINGLE, 0, 0);
    tick;
    HRESP = 1'b0;
    chk("t5_grant0", HGRANT_0, 1);
    chk("t5_beat_after", dut.beat_cnt_q, 0);

    // Reset during INCR8 owned by master 1
    HBUSREQ_0 = 1'b0; HBUSREQ_1 = 1'b1;
    tick;
    chk("t6_grant1", HGRANT_1, 1);
    tick;
    chk("t6_hmaster1", HMASTER, 1);
    drive(1, T_NONSEQ, B_INCR8, 32'h500, 1);
    tick;
    drive(1, T_SEQ, B_INCR8, 32'h504, 1);
    wd(1, 32'hC1); wd(0, 32'hC0);
    tick;
    chk("t6_beat6", dut.beat_cnt_q, 6);
    HRESET = 1'b0;
    #1;
    chk("t6_rst_grant0", HGRANT_0, 1);
    chk("t6_rst_grant1", HGRANT_1, 0);
    chk("t6_rst_hmaster", HMASTER, 0);
    chk("t6_rst_beat", dut.beat_cnt_q, 0);
    chk("t6_rst_htrans", HTRANS, T_IDLE);
    chk("t6_rst_hwdata", HWDATA, 32'hC0);
    HBUSREQ_0 = 1'b1; HBUSREQ_1 = 1'b1;
    drive(1, T_IDLE, B_SINGLE, 0, 0);
    #2 HRESET = 1'b1;
    tick;
    chk("t6_post_grant0", HGRANT_0, 1);
    chk("t6_post_beat", dut.beat_cnt_q, 0);
    drive(0, T_NONSEQ, B_SINGLE, 32'h20, 0);
    HBUSREQ_0 = 1'b0;
    tick;
    chk("t6_post_grant1", HGRANT_1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
